mem_store_unit: RTL

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

---
 rtl/mem_store_unit_if.sv | 37 +++
 rtl/mem_store_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit_if.sv
// Store-buffer bus bundle: EX store request, data SRAM write port and load-hazard probe.
// The DUT side uses the slave modport; the requester/arbiter side uses master.
interface mem_store_unit_if;
  // Store handshake: a store moves on a rising edge where st_valid && st_ready.
  // The requester holds st_* stable while st_valid is high and st_ready is low.
  // st_ready depends only on buffer occupancy, never on st_valid.
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_width;
  logic [1:0]  st_lr;
  logic [31:0] st_addr;
  logic [31:0] st_data;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_gnt;

  logic [31:0] ld_chk_addr;
  logic        ld_hit;
  logic        sb_empty;

  modport master (
    output st_valid, st_width, st_lr, st_addr, st_data,
    output data_sram_gnt, ld_chk_addr,
    input  st_ready, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  ld_hit, sb_empty
  );

  modport slave (
    input  st_valid, st_width, st_lr, st_addr, st_data,
    input  data_sram_gnt, ld_chk_addr,
    output st_ready, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output ld_hit, sb_empty
  );
endinterface

// File: rtl/mem_store_unit.sv
// In-order store buffer between EX and the data SRAM, with lane alignment and load-hit probe.
// Optional macro STORE_MERGE_EN: stores to the tail entry's word coalesce into that entry.
module mem_store_unit #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  mem_store_unit_if.slave   sb_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entry storage: word address, byte enables, lane-aligned data.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [29:0]      waddr_q [DEPTH];
  logic [29:0]      waddr_d [DEPTH];
  logic [3:0]       wen_q   [DEPTH];
  logic [3:0]       wen_d   [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]  off;
  logic [3:0]  fmt_wen;
  logic [31:0] fmt_wdata;
  logic        sb_empty_c;
  logic        st_ready_c;
  logic        accept;
  logic        store_ok;
  logic        push;
  logic        pop;
  logic        ld_hit_c;
  logic        unused_ld_off;

  assign off = sb_if.st_addr[1:0];

  // Lane alignment of the incoming store; width 00 yields no lanes.
  always_comb begin
    fmt_wen   = 4'b0000;
    fmt_wdata = 32'h0;
    if (sb_if.st_width == 2'b11 && sb_if.st_lr == 2'b10) begin
      case (off)
        2'b00:   fmt_wen = 4'b0001;
        2'b01:   fmt_wen = 4'b0011;
        2'b10:   fmt_wen = 4'b0111;
        default: fmt_wen = 4'b1111;
      endcase
      fmt_wdata = sb_if.st_data >> {2'd3 - off, 3'b000};
    end else if (sb_if.st_width == 2'b11 && sb_if.st_lr == 2'b01) begin
      fmt_wen   = 4'b1111 << off;
      fmt_wdata = sb_if.st_data << {off, 3'b000};
    end else begin
      case (sb_if.st_width)
        2'b01: begin
          fmt_wen   = 4'b0001 << off;
          fmt_wdata = {4{sb_if.st_data[7:0]}};
        end
        2'b10: begin
          fmt_wen   = off[1] ? 4'b1100 : 4'b0011;
          fmt_wdata = {2{sb_if.st_data[15:0]}};
        end
        2'b11: begin
          fmt_wen   = 4'b1111;
          fmt_wdata = sb_if.st_data;
        end
        default: begin
          fmt_wen   = 4'b0000;
          fmt_wdata = 32'h0;
        end
      endcase
    end
  end

  assign sb_empty_c = (count_q == '0);
  assign st_ready_c = (count_q < DEPTH_C);
  assign accept     = sb_if.st_valid && st_ready_c;
  assign store_ok   = accept && (sb_if.st_width != 2'b00);
  assign pop        = !sb_empty_c && sb_if.data_sram_gnt;

`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0] tail_last;
  logic             merge;
  logic [31:0]      lane_mask;

  assign tail_last = tail_q - 1'b1;
  assign lane_mask = {{8{fmt_wen[3]}}, {8{fmt_wen[2]}}, {8{fmt_wen[1]}}, {8{fmt_wen[0]}}};
  // The head leaving this cycle is no longer a merge target.
  assign merge = store_ok && valid_q[tail_last]
               && (waddr_q[tail_last] == sb_if.st_addr[31:2])
               && !(pop && (tail_last == head_q));
  assign push  = store_ok && !merge;
`else
  assign push  = store_ok;
`endif

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      waddr_d[tail_q] = sb_if.st_addr[31:2];
      wen_d[tail_q]   = fmt_wen;
      wdata_d[tail_q] = fmt_wdata;
      tail_d          = tail_q + 1'b1;
    end

`ifdef STORE_MERGE_EN
    if (merge) begin
      wen_d[tail_last]   = wen_q[tail_last] | fmt_wen;
      wdata_d[tail_last] = (wdata_q[tail_last] & ~lane_mask) | (fmt_wdata & lane_mask);
    end
`endif

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wen_q[i]   <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  // Load hazard probe sees registered entries only, so a store accepted this cycle is excluded.
  always_comb begin
    ld_hit_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (waddr_q[i] == sb_if.ld_chk_addr[31:2])) ld_hit_c = 1'b1;
    end
  end

  assign unused_ld_off = ^sb_if.ld_chk_addr[1:0];

  assign sb_if.st_ready       = st_ready_c;
  assign sb_if.sb_empty       = sb_empty_c;
  assign sb_if.ld_hit         = ld_hit_c;
  assign sb_if.data_sram_en   = !sb_empty_c;
  assign sb_if.data_sram_wen  = sb_empty_c ? 4'b0000 : wen_q[head_q];
  assign sb_if.data_sram_addr = sb_empty_c ? 32'h0 : {waddr_q[head_q], 2'b00};
  assign sb_if.data_sram_wdata = sb_empty_c ? 32'h0 : wdata_q[head_q];

endmodule
